// File: rtl/decode_stage_hz.sv
// decode_stage_hz: ID-stage decode, early branch resolution, RAW/back-pressure interlock and ID/EX register.
// Optional feature macro DECODE_FORWARD_EN: forward MEM-stage results into the branch compare and ID/EX operands.

module decode_stage_hz_ctrl (
  input  logic [31:0] i_ir,
  input  logic        i_reg_s_t_equal,
  output logic [3:0]  o_alu_op,
  output logic [1:0]  o_alu_a_sel,
  output logic [1:0]  o_alu_b_sel,
  output logic [3:0]  o_mem_we,
  output logic        o_reg_d_we,
  output logic        o_reg_d_addr_sel,
  output logic        o_reg_d_data_sel,
  output logic        o_is_branch,
  output logic        o_pc_we
);
  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = i_ir[31:26];
  assign w_funct  = i_ir[5:0];

  always_comb begin
    o_alu_op         = 4'd0;
    o_alu_a_sel      = 2'd0;
    o_alu_b_sel      = 2'd0;
    o_mem_we         = 4'd0;
    o_reg_d_we       = 1'b0;
    o_reg_d_addr_sel = 1'b0;
    o_reg_d_data_sel = 1'b0;
    o_is_branch      = 1'b0;
    o_pc_we          = 1'b0;
    case (w_opcode)
      6'h00: begin
        o_reg_d_addr_sel = 1'b1;
        case (w_funct)
          6'h20: begin o_alu_op = 4'd0; o_reg_d_we = 1'b1; end
          6'h22: begin o_alu_op = 4'd1; o_reg_d_we = 1'b1; end
          6'h24: begin o_alu_op = 4'd2; o_reg_d_we = 1'b1; end
          6'h25: begin o_alu_op = 4'd3; o_reg_d_we = 1'b1; end
          6'h2A: begin o_alu_op = 4'd4; o_reg_d_we = 1'b1; end
          default: ;
        endcase
      end
      6'h08: begin o_alu_b_sel = 2'd1; o_reg_d_we = 1'b1; end
      6'h0F: begin
        o_alu_op    = 4'd5;
        o_alu_a_sel = 2'd2;
        o_alu_b_sel = 2'd2;
        o_reg_d_we  = 1'b1;
      end
      6'h23: begin o_alu_b_sel = 2'd1; o_reg_d_we = 1'b1; o_reg_d_data_sel = 1'b1; end
      6'h2B: begin o_alu_b_sel = 2'd1; o_mem_we = 4'hF; end
      6'h04: begin o_alu_op = 4'd1; o_is_branch = 1'b1; o_pc_we = i_reg_s_t_equal; end
      6'h05: begin o_alu_op = 4'd1; o_is_branch = 1'b1; o_pc_we = ~i_reg_s_t_equal; end
      default: ;
    endcase
  end
endmodule

module decode_stage_hz #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid_id,
  input  logic [DATA_WIDTH-1:0]      i_pc_id,
  input  logic [31:0]                i_ir_id,
  input  logic [DATA_WIDTH-1:0]      i_reg_s_data_id,
  input  logic [DATA_WIDTH-1:0]      i_reg_t_data_id,
  input  logic                       i_flush_id,
  input  logic                       i_ready_ex,
  input  logic                       i_reg_d_we_mem,
  input  logic [REG_ADDR_WIDTH-1:0]  i_reg_d_addr_mem,
  input  logic [DATA_WIDTH-1:0]      i_reg_d_data_mem,
  output logic                       o_stall_id,
  output logic                       o_pc_we_id,
  output logic [DATA_WIDTH-1:0]      o_pc_data_id,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_s_addr_id,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_t_addr_id,
  output logic                       o_valid_ex,
  output logic [3:0]                 o_alu_op_ex,
  output logic [1:0]                 o_alu_a_sel_ex,
  output logic [1:0]                 o_alu_b_sel_ex,
  output logic [3:0]                 o_mem_we_ex,
  output logic [DATA_WIDTH-1:0]      o_imm_ex,
  output logic [DATA_WIDTH-1:0]      o_reg_s_data_ex,
  output logic [DATA_WIDTH-1:0]      o_reg_t_data_ex,
  output logic                       o_reg_d_we_ex,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_d_addr_ex,
  output logic                       o_reg_d_data_sel_ex,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt
);
  logic [REG_ADDR_WIDTH-1:0]  w_rs, w_rt, w_rd, w_reg_d_addr;
  logic [DATA_WIDTH-1:0]      w_imm, w_op_s, w_op_t;
  logic                       w_mem_hz, w_reg_s_t_equal;
  logic [3:0]                 w_alu_op, w_mem_we;
  logic [1:0]                 w_alu_a_sel, w_alu_b_sel;
  logic                       w_reg_d_we, w_reg_d_addr_sel, w_reg_d_data_sel, w_is_branch, w_ctrl_pc_we;
  logic                       w_ex_src_hit, w_load_use, w_br_raw, w_hazard, w_backpressure;

  logic                       r_valid_ex;
  logic [3:0]                 r_alu_op_ex, r_mem_we_ex;
  logic [1:0]                 r_alu_a_sel_ex, r_alu_b_sel_ex;
  logic [DATA_WIDTH-1:0]      r_imm_ex, r_reg_s_data_ex, r_reg_t_data_ex;
  logic                       r_reg_d_we_ex, r_reg_d_data_sel_ex;
  logic [REG_ADDR_WIDTH-1:0]  r_reg_d_addr_ex;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  assign w_rs  = REG_ADDR_WIDTH'(i_ir_id[25:21]);
  assign w_rt  = REG_ADDR_WIDTH'(i_ir_id[20:16]);
  assign w_rd  = REG_ADDR_WIDTH'(i_ir_id[15:11]);
  assign w_imm = {{(DATA_WIDTH-16){i_ir_id[15]}}, i_ir_id[15:0]};

`ifdef DECODE_FORWARD_EN
  logic w_fwd_s, w_fwd_t;
  assign w_fwd_s  = i_reg_d_we_mem & (i_reg_d_addr_mem != '0) & (i_reg_d_addr_mem == w_rs);
  assign w_fwd_t  = i_reg_d_we_mem & (i_reg_d_addr_mem != '0) & (i_reg_d_addr_mem == w_rt);
  assign w_op_s   = w_fwd_s ? i_reg_d_data_mem : i_reg_s_data_id;
  assign w_op_t   = w_fwd_t ? i_reg_d_data_mem : i_reg_t_data_id;
  assign w_mem_hz = 1'b0;
`else
  logic w_unused_mem_data;
  assign w_unused_mem_data = ^i_reg_d_data_mem;
  assign w_op_s   = i_reg_s_data_id;
  assign w_op_t   = i_reg_t_data_id;
  // Without forwarding a branch must wait until the MEM-stage producer reaches the register file.
  assign w_mem_hz = i_reg_d_we_mem & (i_reg_d_addr_mem != '0) &
                    ((i_reg_d_addr_mem == w_rs) | (i_reg_d_addr_mem == w_rt));
`endif

  assign w_reg_s_t_equal = (w_op_s == w_op_t);

  decode_stage_hz_ctrl u_ctrl (
    .i_ir             (i_ir_id),
    .i_reg_s_t_equal  (w_reg_s_t_equal),
    .o_alu_op         (w_alu_op),
    .o_alu_a_sel      (w_alu_a_sel),
    .o_alu_b_sel      (w_alu_b_sel),
    .o_mem_we         (w_mem_we),
    .o_reg_d_we       (w_reg_d_we),
    .o_reg_d_addr_sel (w_reg_d_addr_sel),
    .o_reg_d_data_sel (w_reg_d_data_sel),
    .o_is_branch      (w_is_branch),
    .o_pc_we          (w_ctrl_pc_we)
  );

  assign w_reg_d_addr   = w_reg_d_addr_sel ? w_rd : w_rt;
  assign w_ex_src_hit   = (r_reg_d_addr_ex != '0) &
                          ((r_reg_d_addr_ex == w_rs) | (r_reg_d_addr_ex == w_rt));
  assign w_load_use     = r_valid_ex & r_reg_d_we_ex & r_reg_d_data_sel_ex & w_ex_src_hit;
  assign w_br_raw       = w_is_branch & ((r_valid_ex & r_reg_d_we_ex & w_ex_src_hit) | w_mem_hz);
  // A flushed instruction is discarded, so its operand hazards no longer matter.
  assign w_hazard       = i_valid_id & ~i_flush_id & (w_load_use | w_br_raw);
  assign w_backpressure = r_valid_ex & ~i_ready_ex;

  assign o_stall_id      = w_hazard | (i_valid_id & w_backpressure);
  assign o_pc_we_id      = w_ctrl_pc_we & i_valid_id & ~o_stall_id & ~i_flush_id;
  assign o_pc_data_id    = i_pc_id + w_imm;
  assign o_reg_s_addr_id = w_rs;
  assign o_reg_t_addr_id = w_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_ex          <= 1'b0;
      r_alu_op_ex         <= '0;
      r_alu_a_sel_ex      <= '0;
      r_alu_b_sel_ex      <= '0;
      r_mem_we_ex         <= '0;
      r_imm_ex            <= '0;
      r_reg_s_data_ex     <= '0;
      r_reg_t_data_ex     <= '0;
      r_reg_d_we_ex       <= 1'b0;
      r_reg_d_addr_ex     <= '0;
      r_reg_d_data_sel_ex <= 1'b0;
    end else if (w_backpressure) begin
      r_valid_ex <= r_valid_ex;
    end else if (w_hazard | i_flush_id | ~i_valid_id) begin
      // Bubble: only the fields that cause side effects downstream are cleared.
      r_valid_ex    <= 1'b0;
      r_reg_d_we_ex <= 1'b0;
      r_mem_we_ex   <= '0;
    end else begin
      r_valid_ex          <= 1'b1;
      r_alu_op_ex         <= w_alu_op;
      r_alu_a_sel_ex      <= w_alu_a_sel;
      r_alu_b_sel_ex      <= w_alu_b_sel;
      r_mem_we_ex         <= w_mem_we;
      r_imm_ex            <= w_imm;
      r_reg_s_data_ex     <= w_op_s;
      r_reg_t_data_ex     <= w_op_t;
      r_reg_d_we_ex       <= w_reg_d_we;
      r_reg_d_addr_ex     <= w_reg_d_addr;
      r_reg_d_data_sel_ex <= w_reg_d_data_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (o_stall_id && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
  end

  assign o_valid_ex          = r_valid_ex;
  assign o_alu_op_ex         = r_alu_op_ex;
  assign o_alu_a_sel_ex      = r_alu_a_sel_ex;
  assign o_alu_b_sel_ex      = r_alu_b_sel_ex;
  assign o_mem_we_ex         = r_mem_we_ex;
  assign o_imm_ex            = r_imm_ex;
  assign o_reg_s_data_ex     = r_reg_s_data_ex;
  assign o_reg_t_data_ex     = r_reg_t_data_ex;
  assign o_reg_d_we_ex       = r_reg_d_we_ex;
  assign o_reg_d_addr_ex     = r_reg_d_addr_ex;
  assign o_reg_d_data_sel_ex = r_reg_d_data_sel_ex;
  assign o_stall_cnt         = r_stall_cnt;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: table-driven rows with an EX-expectation scoreboard, plus saturation and async-reset sequences.
module tb_decode_stage_hz;
`ifdef DECODE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int SCW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_id = 1'b0, flush_id = 1'b0, ready_ex = 1'b1, mem_we = 1'b0;
  logic [31:0] pc_id = '0, ir_id = '0, s_data = '0, t_data = '0, mem_data = '0;
  logic [4:0]  mem_addr = '0;
  logic        stall_id, pc_we_id, valid_ex, reg_d_we_ex, reg_d_data_sel_ex;
  logic [31:0] pc_data_id, imm_ex, s_ex, t_ex;
  logic [4:0]  s_addr_id, t_addr_id, reg_d_addr_ex;
  logic [3:0]  alu_op_ex, mem_we_ex;
  logic [1:0]  a_sel_ex, b_sel_ex;
  logic [SCW-1:0] stall_cnt;

  decode_stage_hz #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(SCW)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid_id(valid_id), .i_pc_id(pc_id), .i_ir_id(ir_id),
    .i_reg_s_data_id(s_data), .i_reg_t_data_id(t_data), .i_flush_id(flush_id), .i_ready_ex(ready_ex),
    .i_reg_d_we_mem(mem_we), .i_reg_d_addr_mem(mem_addr), .i_reg_d_data_mem(mem_data),
    .o_stall_id(stall_id), .o_pc_we_id(pc_we_id), .o_pc_data_id(pc_data_id),
    .o_reg_s_addr_id(s_addr_id), .o_reg_t_addr_id(t_addr_id), .o_valid_ex(valid_ex),
    .o_alu_op_ex(alu_op_ex), .o_alu_a_sel_ex(a_sel_ex), .o_alu_b_sel_ex(b_sel_ex), .o_mem_we_ex(mem_we_ex),
    .o_imm_ex(imm_ex), .o_reg_s_data_ex(s_ex), .o_reg_t_data_ex(t_ex), .o_reg_d_we_ex(reg_d_we_ex),
    .o_reg_d_addr_ex(reg_d_addr_ex), .o_reg_d_data_sel_ex(reg_d_data_sel_ex), .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        full;
    logic        valid;
    logic [3:0]  alu_op;
    logic [1:0]  b_sel;
    logic        we;
    logic [4:0]  addr;
    logic        dsel;
    logic [3:0]  mem_we;
    logic [31:0] s;
  } ex_t;

  typedef struct packed {
    logic        valid, flush, ready, mw;
    logic [31:0] ir, pc, s, t, md;
    logic [4:0]  ma;
    logic        stall, pcwe;
    logic [31:0] pcd;
    ex_t         ex;
  } vec_t;

  vec_t vecs[$];
  ex_t  sb[$];
  int   n_cmp = 0, n_err = 0, exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic ex_t exf(logic [3:0] op, logic [1:0] bs, logic we, logic [4:0] a, logic ds, logic [3:0] mwe, logic [31:0] s);
    return '{full: 1'b1, valid: 1'b1, alu_op: op, b_sel: bs, we: we, addr: a, dsel: ds, mem_we: mwe, s: s};
  endfunction
  function automatic ex_t exb();
    return '{default: '0};
  endfunction
  function automatic vec_t mk(logic v, logic [31:0] ir, logic [31:0] pc, logic [31:0] s, logic [31:0] t,
                              logic fl, logic rdy, logic mw, logic [4:0] ma, logic [31:0] md,
                              logic st, logic pw, logic [31:0] pcd, ex_t ex);
    return '{valid: v, flush: fl, ready: rdy, mw: mw, ir: ir, pc: pc, s: s, t: t, md: md, ma: ma,
             stall: st, pcwe: pw, pcd: pcd, ex: ex};
  endfunction

  logic [31:0] LW, ADD, BEQ, BNE, ADDI, ADD0, BEQ0, SW, SUB;

  initial begin
    vec_t v;
    ex_t  e;
    LW   = i_ins(6'h23, 5'd1, 5'd2, 16'h0000);
    ADD  = r_ins(5'd2, 5'd1, 5'd3, 6'h20);
    BEQ  = i_ins(6'h04, 5'd4, 5'd5, 16'h0010);
    BNE  = i_ins(6'h05, 5'd4, 5'd5, 16'hFFF0);
    ADDI = i_ins(6'h08, 5'd0, 5'd4, 16'h0005);
    ADD0 = r_ins(5'd1, 5'd1, 5'd0, 6'h20);
    BEQ0 = i_ins(6'h04, 5'd0, 5'd0, 16'h0008);
    SW   = i_ins(6'h2B, 5'd1, 5'd2, 16'h0004);
    SUB  = r_ins(5'd7, 5'd8, 5'd6, 6'h22);

    //          v  ir    pc      s      t      fl rdy mw ma  md     stall  pcwe  pcd      expected EX
    vecs.push_back(mk(0, ADD,  0,      0,     0,     0, 1, 0, 0, 0,     0,    0,    0,     exb()));
    vecs.push_back(mk(1, LW,   32'h4,  32'h40,0,     0, 1, 0, 0, 0,     0,    0,    0,     exf(0, 1, 1, 2, 1, 0, 32'h40)));
    vecs.push_back(mk(1, ADD,  32'h8,  32'h11,32'h22,0, 1, 0, 0, 0,     1,    0,    0,     exb()));
    vecs.push_back(mk(1, ADD,  32'h8,  32'h11,32'h22,0, 1, 0, 0, 0,     0,    0,    0,     exf(0, 0, 1, 3, 0, 0, 32'h11)));
    vecs.push_back(mk(1, BEQ,  32'h100,7,     7,     0, 1, 0, 0, 0,     0,    1, 32'h110,  exf(1, 0, 0, 5, 0, 0, 7)));
    vecs.push_back(mk(1, BEQ,  32'h200,7,     8,     0, 1, 0, 0, 0,     0,    0,    0,     exf(1, 0, 0, 5, 0, 0, 7)));
    vecs.push_back(mk(1, BNE,  32'h200,7,     8,     0, 1, 0, 0, 0,     0,    1, 32'h1F0,  exf(1, 0, 0, 5, 0, 0, 7)));
    vecs.push_back(mk(1, BEQ,  32'h100,3,     7,     0, 1, 1, 4, 7,     !FWD, FWD, 32'h110, FWD ? exf(1, 0, 0, 5, 0, 0, 7) : exb()));
    vecs.push_back(mk(1, BEQ,  32'h100,7,     7,     0, 1, 0, 0, 0,     0,    1, 32'h110,  exf(1, 0, 0, 5, 0, 0, 7)));
    vecs.push_back(mk(1, ADDI, 32'h104,0,     0,     0, 1, 0, 0, 0,     0,    0,    0,     exf(0, 1, 1, 4, 0, 0, 0)));
    vecs.push_back(mk(1, BEQ,  32'h108,0,     5,     0, 1, 0, 0, 0,     1,    0,    0,     exb()));
    vecs.push_back(mk(1, BEQ,  32'h108,0,     5,     0, 1, 1, 4, 5,     !FWD, FWD, 32'h118, FWD ? exf(1, 0, 0, 5, 0, 0, 5) : exb()));
    vecs.push_back(mk(1, ADD0, 32'h10C,9,     9,     0, 1, 0, 0, 0,     0,    0,    0,     exf(0, 0, 1, 0, 0, 0, 9)));
    vecs.push_back(mk(1, BEQ0, 32'h300,0,     0,     0, 1, 0, 0, 0,     0,    1, 32'h308,  exf(1, 0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, ADD, 32'h304,32'h11,32'h22,0, 0, 0, 0, 0,   1,    0,    0,     exf(1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(1, ADD,  32'h304,32'h11,32'h22,1, 1, 0, 0, 0,     0,    0,    0,     exb()));
    vecs.push_back(mk(1, LW,   32'h4,  32'h40,0,     0, 1, 0, 0, 0,     0,    0,    0,     exf(0, 1, 1, 2, 1, 0, 32'h40)));
    vecs.push_back(mk(1, ADD,  32'h8,  32'h11,32'h22,1, 1, 0, 0, 0,     0,    0,    0,     exb()));
    vecs.push_back(mk(1, ADD,  32'h8,  32'h11,32'h22,0, 0, 0, 0, 0,     0,    0,    0,     exf(0, 0, 1, 3, 0, 0, 32'h11)));
    vecs.push_back(mk(1, SW,   32'hC,  32'h50,32'h60,0, 1, 0, 0, 0,     0,    0,    0,     exf(0, 1, 0, 2, 0, 4'hF, 32'h50)));
    vecs.push_back(mk(1, SUB,  32'h10, 32'h70,32'h80,0, 1, 0, 0, 0,     0,    0,    0,     exf(1, 0, 1, 6, 0, 0, 32'h70)));

    // Power-on reset state.
    #1;
    chk("por valid_ex", valid_ex, 0);
    chk("por stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      valid_id = v.valid; ir_id = v.ir; pc_id = v.pc; s_data = v.s; t_data = v.t;
      flush_id = v.flush; ready_ex = v.ready; mem_we = v.mw; mem_addr = v.ma; mem_data = v.md;
      sb.push_back(v.ex);
      #1;
      chk($sformatf("row%0d stall_id", i), stall_id, v.stall);
      chk($sformatf("row%0d pc_we_id", i), pc_we_id, v.pcwe);
      if (v.pcwe) chk($sformatf("row%0d pc_data_id", i), pc_data_id, v.pcd);
      chk($sformatf("row%0d reg_s_addr_id", i), s_addr_id, v.ir[25:21]);
      chk($sformatf("row%0d reg_t_addr_id", i), t_addr_id, v.ir[20:16]);
      if (v.stall && exp_cnt < 15) exp_cnt++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d valid_ex", i), valid_ex, e.valid);
      chk($sformatf("row%0d reg_d_we_ex", i), reg_d_we_ex, e.we);
      chk($sformatf("row%0d mem_we_ex", i), mem_we_ex, e.mem_we);
      if (e.full) begin
        chk($sformatf("row%0d alu_op_ex", i), alu_op_ex, e.alu_op);
        chk($sformatf("row%0d alu_b_sel_ex", i), b_sel_ex, e.b_sel);
        chk($sformatf("row%0d reg_d_addr_ex", i), reg_d_addr_ex, e.addr);
        chk($sformatf("row%0d reg_d_data_sel_ex", i), reg_d_data_sel_ex, e.dsel);
        chk($sformatf("row%0d reg_s_data_ex", i), s_ex, e.s);
      end
      chk($sformatf("row%0d stall_cnt", i), stall_cnt, exp_cnt);
      $display("row %0d ir=%08h stall=%b pc_we=%b valid_ex=%b cnt=%0d", i, v.ir, stall_id, pc_we_id, valid_ex, stall_cnt);
    end

    // Saturation: 20 back-pressure cycles with SUB held in EX.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      valid_id = 1'b1; ir_id = ADD; flush_id = 1'b0; ready_ex = 1'b0; mem_we = 1'b0;
      #1;
      chk($sformatf("sat%0d stall_id", k), stall_id, 1);
      if (exp_cnt < 15) exp_cnt++;
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d stall_cnt", k), stall_cnt, exp_cnt);
    end
    chk("sat final stall_cnt", stall_cnt, 15);
    chk("sat held alu_op_ex", alu_op_ex, 1);
    chk("sat held reg_d_addr_ex", reg_d_addr_ex, 6);
    $display("saturation cnt=%0d valid_ex=%b", stall_cnt, valid_ex);

    // Asynchronous reset mid-cycle with EX valid.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst valid_ex", valid_ex, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst ex fields or", 32'(|{alu_op_ex, a_sel_ex, b_sel_ex, mem_we_ex, imm_ex, s_ex, t_ex,
                                  reg_d_we_ex, reg_d_addr_ex, reg_d_data_sel_ex}), 0);
    $display("async reset valid_ex=%b cnt=%0d", valid_ex, stall_cnt);

    // First instruction after reset release decodes with no stale hazard.
    @(negedge clk);
    rst_n = 1'b1; valid_id = 1'b1; ir_id = ADD; s_data = 32'h11; t_data = 32'h22; ready_ex = 1'b1;
    #1;
    chk("post-rst stall_id", stall_id, 0);
    @(posedge clk);
    #1;
    chk("post-rst valid_ex", valid_ex, 1);
    chk("post-rst reg_d_addr_ex", reg_d_addr_ex, 3);
    chk("post-rst reg_s_data_ex", s_ex, 32'h11);
    chk("post-rst reg_t_data_ex", t_ex, 32'h22);
    $display("post-reset valid_ex=%b rd=%0d", valid_ex, reg_d_addr_ex);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
